// File: rtl/triangle_setup_if.sv
// Triangle setup bus: upstream triangle handshake plus the coefficient,
// start/eoc and done hand-off toward the pixel computation stage.
interface triangle_setup_if #(
  parameter int COORD_WIDTH = 16,
  parameter int COLOR_WIDTH = 16
);

  logic                          tri_valid;
  logic                          tri_ready;
  logic signed [COORD_WIDTH-1:0] vx [3];
  logic signed [COORD_WIDTH-1:0] vy [3];
  logic        [COLOR_WIDTH-1:0] tri_color;

  logic                            start;
  logic signed [COORD_WIDTH-1:0]   bound_coefs [3][2];
  logic signed [2*COORD_WIDTH-1:0] bound_const [3];
  logic        [COLOR_WIDTH-1:0]   color;
  logic                            eoc;
  logic                            done;
  logic                            degenerate;

  // Environment side: offers triangles and reports end of computation.
  modport master (
    output tri_valid, vx, vy, tri_color, eoc,
    input  tri_ready, start, bound_coefs, bound_const, color, done, degenerate
  );

  // Setup block side.
  modport slave (
    input  tri_valid, vx, vy, tri_color, eoc,
    output tri_ready, start, bound_coefs, bound_const, color, done, degenerate
  );

endinterface

// File: rtl/triangle_setup.sv
// Triangle setup: latches a triangle, derives the three edge equations
// A*x + B*y + C with one shared multiplier pair, orients them so interior
// pixels evaluate positive, launches pixel computation and waits for eoc.
// Zero-area triangles are dropped with a done/degenerate pulse.
module triangle_setup #(
  parameter int COORD_WIDTH = 16,
  parameter int COLOR_WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  triangle_setup_if.slave  bus
);

  localparam int PW = 2 * COORD_WIDTH;
  localparam int SW = 2 * COORD_WIDTH + 2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP0,
    SETUP1,
    SETUP2,
    ORIENT,
    START,
    WAIT_EOC
  } state_t;

  state_t state;

  logic signed [COORD_WIDTH-1:0] x_q [3];
  logic signed [COORD_WIDTH-1:0] y_q [3];

  logic signed [COORD_WIDTH-1:0] a_q [3];
  logic signed [COORD_WIDTH-1:0] b_q [3];
  logic signed [PW-1:0]          c_q [3];
  logic        [COLOR_WIDTH-1:0] color_q;

  logic start_q;
  logic done_q;
  logic degenerate_q;

  logic        [1:0]             edge_sel;
  logic signed [COORD_WIDTH-1:0] xi;
  logic signed [COORD_WIDTH-1:0] yi;
  logic signed [COORD_WIDTH-1:0] xj;
  logic signed [COORD_WIDTH-1:0] yj;

  logic signed [PW-1:0]          prod_a;
  logic signed [PW-1:0]          prod_b;
  logic signed [COORD_WIDTH-1:0] edge_a;
  logic signed [COORD_WIDTH-1:0] edge_b;
  logic signed [PW-1:0]          edge_c;

  logic signed [SW-1:0]          area_sum;
  logic                          area_neg;
  logic                          area_zero;

  // Pick the edge endpoints (vertex i and vertex i+1 mod 3) for the current setup step.
  always_comb begin
    edge_sel = 2'd0;
    xi       = x_q[0];
    yi       = y_q[0];
    xj       = x_q[1];
    yj       = y_q[1];
    case (state)
      SETUP1: begin
        edge_sel = 2'd1;
        xi       = x_q[1];
        yi       = y_q[1];
        xj       = x_q[2];
        yj       = y_q[2];
      end
      SETUP2: begin
        edge_sel = 2'd2;
        xi       = x_q[2];
        yi       = y_q[2];
        xj       = x_q[0];
        yj       = y_q[0];
      end
      default: begin
      end
    endcase
  end

  // Shared multiplier pair and edge coefficient arithmetic (wrapping widths).
  always_comb begin
    prod_a = PW'(xi) * PW'(yj);
    prod_b = PW'(xj) * PW'(yi);
    edge_c = prod_a - prod_b;
    edge_a = yi - yj;
    edge_b = xj - xi;
  end

  // Twice the signed area, widened so three full-range constants cannot overflow.
  always_comb begin
    area_sum  = $signed({{2{c_q[0][PW-1]}}, c_q[0]})
              + $signed({{2{c_q[1][PW-1]}}, c_q[1]})
              + $signed({{2{c_q[2][PW-1]}}, c_q[2]});
    area_neg  = area_sum[SW-1];
    area_zero = (area_sum == '0);
  end

  // Control FSM with registered datapath and pulse outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      done_q       <= 1'b0;
      degenerate_q <= 1'b0;
      color_q      <= '0;
      for (int i = 0; i < 3; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
        a_q[i] <= '0;
        b_q[i] <= '0;
        c_q[i] <= '0;
      end
    end else begin
      start_q      <= 1'b0;
      done_q       <= 1'b0;
      degenerate_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.tri_valid) begin
            for (int i = 0; i < 3; i++) begin
              x_q[i] <= bus.vx[i];
              y_q[i] <= bus.vy[i];
            end
            color_q <= bus.tri_color;
            state   <= SETUP0;
          end
        end
        SETUP0, SETUP1, SETUP2: begin
          a_q[edge_sel] <= edge_a;
          b_q[edge_sel] <= edge_b;
          c_q[edge_sel] <= edge_c;
          case (state)
            SETUP0:  state <= SETUP1;
            SETUP1:  state <= SETUP2;
            default: state <= ORIENT;
          endcase
        end
        ORIENT: begin
          if (area_zero) begin
            done_q       <= 1'b1;
            degenerate_q <= 1'b1;
            state        <= IDLE;
          end else begin
            if (area_neg) begin
              for (int i = 0; i < 3; i++) begin
                a_q[i] <= -a_q[i];
                b_q[i] <= -b_q[i];
                c_q[i] <= -c_q[i];
              end
            end
            start_q <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          state <= WAIT_EOC;
        end
        WAIT_EOC: begin
          if (bus.eoc) begin
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.tri_ready  = (state == IDLE);
  assign bus.start      = start_q;
  assign bus.done       = done_q;
  assign bus.degenerate = degenerate_q;
  assign bus.color      = color_q;

  // Present the coefficient registers on the output bus.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      bus.bound_coefs[i][0] = a_q[i];
      bus.bound_coefs[i][1] = b_q[i];
      bus.bound_const[i]    = c_q[i];
    end
  end

endmodule

// File: tb/tb_triangle_setup.sv
// Directed self-checking bench for triangle_setup with hand-computed edge
// coefficients, degenerate handling, eoc gating, back-to-back accept and reset.
module tb_triangle_setup;

  localparam int CW = 16;
  localparam int KW = 16;

  logic clk;
  logic reset_n;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  triangle_setup_if #(.COORD_WIDTH(CW), .COLOR_WIDTH(KW)) bus ();

  triangle_setup #(.COORD_WIDTH(CW), .COLOR_WIDTH(KW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                             input logic signed [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic driveTriangle(input int x0, input int y0, input int x1, input int y1,
                               input int x2, input int y2, input int col);
    bus.vx[0]     = CW'(x0);
    bus.vy[0]     = CW'(y0);
    bus.vx[1]     = CW'(x1);
    bus.vy[1]     = CW'(y1);
    bus.vx[2]     = CW'(x2);
    bus.vy[2]     = CW'(y2);
    bus.tri_color = KW'(col);
  endtask

  task automatic applyStimulus(input int x0, input int y0, input int x1, input int y1,
                               input int x2, input int y2, input int col);
    driveTriangle(x0, y0, x1, y1, x2, y2, col);
    bus.tri_valid = 1'b1;
    @(negedge clk);
    checkOutput("accept_ready", bus.tri_ready, 1);
    cyc = 0;
    nextCycle();
    bus.tri_valid = 1'b0;
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_start"}, bus.start, 0);
    checkOutput({name, "_done"}, bus.done, 0);
    checkOutput({name, "_degen"}, bus.degenerate, 0);
    checkOutput({name, "_color"}, bus.color, 0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("%s_A%0d", name, i), bus.bound_coefs[i][0], 0);
      checkOutput($sformatf("%s_B%0d", name, i), bus.bound_coefs[i][1], 0);
      checkOutput($sformatf("%s_C%0d", name, i), bus.bound_const[i], 0);
    end
  endtask

  task automatic expectStart(input string name, input int ea[3], input int eb[3],
                             input int ec[3], input int col);
    while (cyc < 5) begin
      @(negedge clk);
      checkOutput($sformatf("%s_start_c%0d", name, cyc), bus.start, 0);
      checkOutput($sformatf("%s_done_c%0d", name, cyc), bus.done, 0);
      nextCycle();
    end
    @(negedge clk);
    checkOutput({name, "_start_c5"}, bus.start, 1);
    checkOutput({name, "_done_c5"}, bus.done, 0);
    checkOutput({name, "_ready_c5"}, bus.tri_ready, 0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("%s_A%0d", name, i), bus.bound_coefs[i][0], ea[i]);
      checkOutput($sformatf("%s_B%0d", name, i), bus.bound_coefs[i][1], eb[i]);
      checkOutput($sformatf("%s_C%0d", name, i), bus.bound_const[i], ec[i]);
    end
    checkOutput({name, "_color"}, bus.color, col);
  endtask

  task automatic finishTriangle(input string name, input int eoc_cycle, input int c1);
    while (cyc < eoc_cycle) begin
      nextCycle();
      @(negedge clk);
      checkOutput($sformatf("%s_start_c%0d", name, cyc), bus.start, 0);
      checkOutput($sformatf("%s_done_c%0d", name, cyc), bus.done, 0);
      checkOutput($sformatf("%s_ready_c%0d", name, cyc), bus.tri_ready, 0);
      checkOutput($sformatf("%s_hold_c%0d", name, cyc), bus.bound_const[1], c1);
    end
    bus.eoc = 1'b1;
    nextCycle();
    bus.eoc = 1'b0;
    @(negedge clk);
    checkOutput({name, "_done"}, bus.done, 1);
    checkOutput({name, "_degen"}, bus.degenerate, 0);
    checkOutput({name, "_ready"}, bus.tri_ready, 1);
    nextCycle();
    @(negedge clk);
    checkOutput({name, "_done_after"}, bus.done, 0);
    nextCycle();
  endtask

  initial begin
    bus.tri_valid = 1'b0;
    bus.eoc       = 1'b0;
    driveTriangle(0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #10;
    checkAllZero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    nextCycle();
    @(negedge clk);
    checkOutput("reset_ready", bus.tri_ready, 1);
    checkOutput("reset_start", bus.start, 0);
    nextCycle();

    // Counter-clockwise right triangle: coefficients pass through unchanged.
    applyStimulus(0, 0, 10, 0, 0, 10, 16'h1234);
    expectStart("triA", '{0, -10, 10}, '{10, -10, 0}, '{0, 100, 0}, 16'h1234);
    finishTriangle("triA", 6, 100);

    // Clockwise winding: every coefficient is negated.
    applyStimulus(0, 0, 0, 10, 10, 0, 16'h00AB);
    expectStart("triB", '{10, -10, 0}, '{0, -10, 10}, '{0, 100, 0}, 16'h00AB);
    finishTriangle("triB", 9, 100);

    // Collinear vertices: dropped with done+degenerate, never started.
    applyStimulus(0, 0, 5, 5, 10, 10, 16'h5555);
    while (cyc < 5) begin
      @(negedge clk);
      checkOutput($sformatf("degen_start_c%0d", cyc), bus.start, 0);
      checkOutput($sformatf("degen_done_c%0d", cyc), bus.done, 0);
      nextCycle();
    end
    @(negedge clk);
    checkOutput("degen_done_c5", bus.done, 1);
    checkOutput("degen_flag_c5", bus.degenerate, 1);
    checkOutput("degen_start_c5", bus.start, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("degen_ready_c6", bus.tri_ready, 1);
    checkOutput("degen_done_c6", bus.done, 0);
    checkOutput("degen_flag_c6", bus.degenerate, 0);
    checkOutput("degen_start_c6", bus.start, 0);
    nextCycle();

    // Early eoc pulses ignored; second triangle waits with tri_valid held high.
    applyStimulus(0, 0, 10, 0, 0, 10, 16'h0F0F);
    while (cyc <= 20) begin
      bus.eoc = (cyc == 2) || (cyc == 5) || (cyc == 20);
      if (cyc >= 18) begin
        driveTriangle(0, 0, 0, 10, 10, 0, 16'h7777);
        bus.tri_valid = 1'b1;
      end
      @(negedge clk);
      checkOutput($sformatf("eocgate_start_c%0d", cyc), bus.start, (cyc == 5) ? 1 : 0);
      checkOutput($sformatf("eocgate_done_c%0d", cyc), bus.done, 0);
      checkOutput($sformatf("eocgate_ready_c%0d", cyc), bus.tri_ready, 0);
      if (cyc == 5) begin
        checkOutput("eocgate_C1_c5", bus.bound_const[1], 100);
        checkOutput("eocgate_color_c5", bus.color, 16'h0F0F);
      end
      nextCycle();
    end
    bus.eoc = 1'b0;
    @(negedge clk);
    checkOutput("eocgate_done_c21", bus.done, 1);
    checkOutput("eocgate_degen_c21", bus.degenerate, 0);
    checkOutput("eocgate_ready_c21", bus.tri_ready, 1);
    checkOutput("eocgate_color_c21", bus.color, 16'h0F0F);
    cyc = 0;
    nextCycle();
    bus.tri_valid = 1'b0;
    expectStart("b2b", '{10, -10, 0}, '{0, -10, 10}, '{0, 100, 0}, 16'h7777);

    // Asynchronous reset while waiting for eoc: outputs clear, no done.
    nextCycle();
    nextCycle();
    reset_n = 1'b0;
    bus.eoc = 1'b1;
    #1;
    checkAllZero("midreset");
    @(posedge clk);
    @(negedge clk);
    checkOutput("midreset_done_held", bus.done, 0);
    checkOutput("midreset_start_held", bus.start, 0);
    reset_n = 1'b1;
    bus.eoc = 1'b0;
    nextCycle();
    @(negedge clk);
    checkOutput("postreset_ready", bus.tri_ready, 1);
    checkOutput("postreset_done", bus.done, 0);
    nextCycle();

    // Full-range coordinates: A/B wrap to COORD_WIDTH, C truncated to 2*COORD_WIDTH.
    applyStimulus(-32768, -32768, 32767, -32768, -32768, 32767, 16'hBEEF);
    expectStart("extreme", '{0, 1, -1}, '{-1, 1, 0}, '{2147450880, -65535, 2147450880}, 16'hBEEF);
    finishTriangle("extreme", 12, -65535);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
